// File: rtl/game_pkg.sv
// Shared types and constants for the tank game round sequencing logic.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    COUNTDOWN   = 3'd1,
    PLAY        = 3'd2,
    ROUND_OVER  = 3'd3,
    MATCH_OVER  = 3'd4
  } round_state_t;

  localparam logic [7:0]  KEY_START_DEFAULT = 8'h28;
  localparam int unsigned FRAMES_PER_SEC    = 60;
  localparam int unsigned MAX_PLAYERS       = 4;

  // Number of set bits in an alive mask (players beyond NUM_PLAYERS are zero-padded).
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame_tick down-counter with a once-per-second strobe.
module frame_timer
  import game_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             frame_tick,
  output logic             done,
  output logic             sec_tick
);

  localparam int unsigned SUB_W = $clog2(FRAMES_PER_SEC);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [SUB_W-1:0] r_sub;
  logic [SUB_W-1:0] w_sub_nxt;
  logic             w_count;

  // A load wins over a coincident tick, so the load cycle never counts.
  always_comb begin
    w_count   = frame_tick && !load && (r_cnt != '0);
    w_cnt_nxt = r_cnt;
    w_sub_nxt = r_sub;
    sec_tick  = 1'b0;
    if (load) begin
      w_cnt_nxt = load_val;
      w_sub_nxt = '0;
    end else if (w_count) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
      if (r_sub == SUB_W'(FRAMES_PER_SEC - 1)) begin
        w_sub_nxt = '0;
        sec_tick  = 1'b1;
      end else begin
        w_sub_nxt = r_sub + SUB_W'(1);
      end
    end
  end

  // High from the cycle whose tick brings the count to zero, and while it stays there.
  assign done = (w_cnt_nxt == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt <= '0;
      r_sub <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sub <= w_sub_nxt;
    end
  end

endmodule

// File: rtl/round_controller.sv
// N-player match/round sequencer: countdown, play, round result, scoring and match winner.
module round_controller
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS      = 2,
  parameter int unsigned SCORE_W          = 4,
  parameter int unsigned WIN_SCORE        = 5,
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned ROUNDOVER_FRAMES = 120,
  parameter logic [7:0]  KEY_START        = KEY_START_DEFAULT
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              frame_tick,
  input  logic [7:0]                        keycode,
  input  logic [NUM_PLAYERS-1:0]            hit,
  output logic [2:0]                        state,
  output logic                              round_reset,
  output logic                              play_en,
  output logic [NUM_PLAYERS*SCORE_W-1:0]    score,
  output logic [$clog2(NUM_PLAYERS)-1:0]    round_winner,
  output logic                              round_draw,
  output logic                              match_winner_vld,
  output logic [3:0]                        countdown_sec
);

  localparam int unsigned RW_W    = $clog2(NUM_PLAYERS);
  localparam int unsigned SC_W    = NUM_PLAYERS * SCORE_W;
  localparam int unsigned MAX_FR  = (COUNTDOWN_FRAMES > ROUNDOVER_FRAMES) ?
                                    COUNTDOWN_FRAMES : ROUNDOVER_FRAMES;
  localparam int unsigned CNT_W   = $clog2(MAX_FR + 1);

  round_state_t           r_state, w_state_nxt;
  logic [NUM_PLAYERS-1:0] r_alive, w_alive_nxt, w_alive_upd;
  logic [SC_W-1:0]        r_score, w_score_nxt;
  logic [RW_W-1:0]        r_round_winner, w_winner_nxt;
  logic                   r_round_draw, w_draw_nxt;
  logic [3:0]             r_countdown_sec, w_sec_nxt;
  logic                   r_round_reset, r_play_en, r_match_winner_vld;
  logic                   r_entry, w_entry_nxt;
  logic                   r_key_prev;
  logic                   w_key_hit, w_start, w_enter_cd, w_score_hit;
  logic [2:0]             w_alive_cnt;
  logic                   w_done, w_sec_tick;
  logic [CNT_W-1:0]       w_load_val;

  // Single timer shared by the countdown and the round-over hold.
  frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (r_entry),
    .load_val   (w_load_val),
    .frame_tick (frame_tick),
    .done       (w_done),
    .sec_tick   (w_sec_tick)
  );

  assign w_load_val = (r_state == ROUND_OVER) ? CNT_W'(ROUNDOVER_FRAMES)
                                              : CNT_W'(COUNTDOWN_FRAMES);

  always_comb begin
    w_key_hit    = (keycode == KEY_START);
    w_start      = w_key_hit && !r_key_prev;
    w_alive_upd  = r_alive & ~hit;
    w_alive_cnt  = popcount4(4'(w_alive_upd));
    w_state_nxt  = r_state;
    w_alive_nxt  = r_alive;
    w_score_nxt  = r_score;
    w_winner_nxt = r_round_winner;
    w_draw_nxt   = r_round_draw;
    w_sec_nxt    = r_countdown_sec;
    w_score_hit  = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (r_score[i*SCORE_W +: SCORE_W] == SCORE_W'(WIN_SCORE)) w_score_hit = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = COUNTDOWN;
      end
      COUNTDOWN: begin
        if (w_sec_tick && (r_countdown_sec != 4'd0)) w_sec_nxt = r_countdown_sec - 4'd1;
        if (w_done && !r_entry) w_state_nxt = PLAY;
      end
      PLAY: begin
        w_alive_nxt = w_alive_upd;
        if (w_alive_cnt <= 3'd1) begin
          w_state_nxt = ROUND_OVER;
          w_draw_nxt  = (w_alive_cnt == 3'd0);
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (w_alive_upd[i]) begin
              w_winner_nxt = RW_W'(i);
              if (r_score[i*SCORE_W +: SCORE_W] < SCORE_W'(WIN_SCORE)) begin
                w_score_nxt[i*SCORE_W +: SCORE_W] =
                  r_score[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
              end
            end
          end
        end
      end
      ROUND_OVER: begin
        if (w_done && !r_entry) w_state_nxt = w_score_hit ? MATCH_OVER : COUNTDOWN;
      end
      MATCH_OVER: begin
        if (w_start) begin
          w_score_nxt = '0;
          w_draw_nxt  = 1'b0;
          w_state_nxt = COUNTDOWN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Every fresh round starts with everyone alive and a full countdown display.
    w_enter_cd = (w_state_nxt == COUNTDOWN) && (r_state != COUNTDOWN);
    if (w_enter_cd) begin
      w_alive_nxt = '1;
      w_sec_nxt   = 4'(COUNTDOWN_FRAMES / FRAMES_PER_SEC);
    end
    w_entry_nxt = (w_state_nxt != r_state) &&
                  ((w_state_nxt == COUNTDOWN) || (w_state_nxt == ROUND_OVER));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state            <= IDLE;
      r_alive            <= '1;
      r_score            <= '0;
      r_round_winner     <= '0;
      r_round_draw       <= 1'b0;
      r_countdown_sec    <= 4'd0;
      r_round_reset      <= 1'b0;
      r_play_en          <= 1'b0;
      r_match_winner_vld <= 1'b0;
      r_entry            <= 1'b0;
      r_key_prev         <= 1'b0;
    end else begin
      r_state            <= w_state_nxt;
      r_alive            <= w_alive_nxt;
      r_score            <= w_score_nxt;
      r_round_winner     <= w_winner_nxt;
      r_round_draw       <= w_draw_nxt;
      r_countdown_sec    <= w_sec_nxt;
      r_round_reset      <= w_enter_cd;
      r_play_en          <= (w_state_nxt == PLAY);
      r_match_winner_vld <= (w_state_nxt == MATCH_OVER);
      r_entry            <= w_entry_nxt;
      r_key_prev         <= w_key_hit;
    end
  end

  assign state            = r_state;
  assign round_reset      = r_round_reset;
  assign play_en          = r_play_en;
  assign score            = r_score;
  assign round_winner     = r_round_winner;
  assign round_draw       = r_round_draw;
  assign match_winner_vld = r_match_winner_vld;
  assign countdown_sec    = r_countdown_sec;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: a 2-player and a 4-player instance on a shared clock.
module tb_round_controller;

  logic        clk;
  logic        Reset;
  logic        frame_tick;
  logic [7:0]  keycode;
  logic [1:0]  hit2;
  logic [3:0]  hit4;

  logic [2:0]  state2, state4;
  logic        rr2, rr4, pe2, pe4, draw2, draw4, mwv2, mwv4;
  logic [7:0]  score2;
  logic [15:0] score4;
  logic [0:0]  rw2;
  logic [1:0]  rw4;
  logic [3:0]  cd2, cd4;

  int n_checks;
  int n_pass;
  int n_rr;

  round_controller #(.NUM_PLAYERS(2)) u_dut2 (
    .Clk(clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode), .hit(hit2),
    .state(state2), .round_reset(rr2), .play_en(pe2), .score(score2),
    .round_winner(rw2), .round_draw(draw2), .match_winner_vld(mwv2), .countdown_sec(cd2)
  );

  round_controller #(.NUM_PLAYERS(4)) u_dut4 (
    .Clk(clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode), .hit(hit4),
    .state(state4), .round_reset(rr4), .play_en(pe4), .score(score4),
    .round_winner(rw4), .round_draw(draw4), .match_winner_vld(mwv4), .countdown_sec(cd4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs applied now are sampled at the next posedge; returns at the negedge after.
  task automatic cyc(input logic ft);
    frame_tick = ft;
    @(negedge clk);
  endtask

  task automatic run_cd();
    repeat (181) cyc(1'b1);
  endtask

  task automatic run_ro();
    repeat (121) cyc(1'b1);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    n_checks++;
    if ({state2, rr2, pe2, draw2, mwv2, cd2, score2, rw2} !== 20'd0)
      $display("FAIL reset2: got %h want 0", {state2, rr2, pe2, draw2, mwv2, cd2, score2, rw2});
    else n_pass++;
    n_checks++;
    if ({state4, rr4, pe4, draw4, mwv4, cd4, score4, rw4} !== 29'd0)
      $display("FAIL reset4: got %h want 0", {state4, rr4, pe4, draw4, mwv4, cd4, score4, rw4});
    else n_pass++;
    Reset = 1'b0;
    cyc(1'b0);
  endtask

  task automatic test_start_countdown();
    keycode = 8'h28;
    cyc(1'b0);
    n_checks++;
    if ({state2, rr2, cd2} !== {3'd1, 1'b1, 4'd3})
      $display("FAIL start_entry: got st=%0d rr=%0b sec=%0d want 1 1 3", state2, rr2, cd2);
    else n_pass++;
    n_rr = int'(rr2);
    cyc(1'b1);
    n_rr += int'(rr2);
    repeat (8) begin
      cyc(1'b0);
      n_rr += int'(rr2);
    end
    n_checks++;
    if (n_rr !== 1) $display("FAIL start_one_pulse: got %0d pulses want 1", n_rr);
    else n_pass++;
    keycode = 8'h00;
    repeat (59) cyc(1'b1);
    n_checks++;
    if ({state2, cd2} !== {3'd1, 4'd3})
      $display("FAIL cd_tick59: got st=%0d sec=%0d want 1 3", state2, cd2);
    else n_pass++;
    cyc(1'b1);
    n_checks++;
    if (cd2 !== 4'd2) $display("FAIL cd_tick60: got %0d want 2", cd2);
    else n_pass++;
    repeat (59) cyc(1'b1);
    cyc(1'b1);
    n_checks++;
    if (cd2 !== 4'd1) $display("FAIL cd_tick120: got %0d want 1", cd2);
    else n_pass++;
    repeat (59) cyc(1'b1);
    n_checks++;
    if ({state2, pe2, cd2} !== {3'd1, 1'b0, 4'd1})
      $display("FAIL cd_tick179: got st=%0d pe=%0b sec=%0d want 1 0 1", state2, pe2, cd2);
    else n_pass++;
    cyc(1'b1);
    n_checks++;
    if ({state2, pe2, cd2} !== {3'd2, 1'b1, 4'd0})
      $display("FAIL cd_tick180: got st=%0d pe=%0b sec=%0d want 2 1 0", state2, pe2, cd2);
    else n_pass++;
    n_checks++;
    if ({state4, pe4} !== {3'd2, 1'b1})
      $display("FAIL play4: got st=%0d pe=%0b want 2 1", state4, pe4);
    else n_pass++;
  endtask

  task automatic test_four_players();
    hit4 = 4'b0001; cyc(1'b0);
    hit4 = 4'b0100; cyc(1'b0);
    hit4 = 4'b0100; cyc(1'b0);
    hit4 = 4'b0000; cyc(1'b0);
    n_checks++;
    if ({state4, pe4} !== {3'd2, 1'b1})
      $display("FAIL p4_dup_hit: got st=%0d pe=%0b want 2 1", state4, pe4);
    else n_pass++;
    hit4 = 4'b1000; cyc(1'b0);
    hit4 = 4'b0000;
    n_checks++;
    if ({state4, pe4, draw4} !== {3'd3, 1'b0, 1'b0})
      $display("FAIL p4_end: got st=%0d pe=%0b draw=%0b want 3 0 0", state4, pe4, draw4);
    else n_pass++;
    n_checks++;
    if (rw4 !== 2'd1) $display("FAIL p4_winner: got %0d want 1", rw4);
    else n_pass++;
    n_checks++;
    if (score4 !== 16'h0010) $display("FAIL p4_score: got %h want 0010", score4);
    else n_pass++;
  endtask

  task automatic test_win_round();
    hit2 = 2'b01; cyc(1'b0);
    hit2 = 2'b00;
    n_checks++;
    if ({state2, pe2, draw2} !== {3'd3, 1'b0, 1'b0})
      $display("FAIL win_state: got st=%0d pe=%0b draw=%0b want 3 0 0", state2, pe2, draw2);
    else n_pass++;
    n_checks++;
    if (rw2 !== 1'b1) $display("FAIL win_winner: got %0d want 1", rw2);
    else n_pass++;
    n_checks++;
    if (score2 !== 8'h10) $display("FAIL win_score: got %h want 10", score2);
    else n_pass++;
    repeat (120) cyc(1'b1);
    n_checks++;
    if ({state2, rr2} !== {3'd3, 1'b0})
      $display("FAIL ro_hold: got st=%0d rr=%0b want 3 0", state2, rr2);
    else n_pass++;
    cyc(1'b1);
    n_checks++;
    if ({state2, rr2, cd2} !== {3'd1, 1'b1, 4'd3})
      $display("FAIL ro_to_cd: got st=%0d rr=%0b sec=%0d want 1 1 3", state2, rr2, cd2);
    else n_pass++;
    cyc(1'b0);
    n_checks++;
    if (rr2 !== 1'b0) $display("FAIL ro_rr_width: got %0b want 0", rr2);
    else n_pass++;
    repeat (180) cyc(1'b1);
    n_checks++;
    if (state2 !== 3'd2) $display("FAIL cd_to_play: got %0d want 2", state2);
    else n_pass++;
  endtask

  task automatic test_draw();
    hit2 = 2'b11; cyc(1'b0);
    hit2 = 2'b00;
    n_checks++;
    if ({state2, draw2} !== {3'd3, 1'b1})
      $display("FAIL draw_state: got st=%0d draw=%0b want 3 1", state2, draw2);
    else n_pass++;
    n_checks++;
    if (score2 !== 8'h10) $display("FAIL draw_score: got %h want 10", score2);
    else n_pass++;
    n_checks++;
    if (rw2 !== 1'b1) $display("FAIL draw_winner: got %0d want 1", rw2);
    else n_pass++;
    run_ro();
    run_cd();
  endtask

  task automatic test_match();
    for (int k = 2; k <= 5; k++) begin
      hit2 = 2'b01; cyc(1'b0);
      hit2 = 2'b00;
      n_checks++;
      if (score2[7:4] !== 4'(k)) $display("FAIL match_score_%0d: got %0d want %0d", k, score2[7:4], k);
      else n_pass++;
      run_ro();
      if (k < 5) run_cd();
    end
    n_checks++;
    if ({state2, mwv2, pe2} !== {3'd4, 1'b1, 1'b0})
      $display("FAIL match_over: got st=%0d vld=%0b pe=%0b want 4 1 0", state2, mwv2, pe2);
    else n_pass++;
    n_checks++;
    if ({score2, rw2} !== {8'h50, 1'b1})
      $display("FAIL match_result: got score=%h rw=%0d want 50 1", score2, rw2);
    else n_pass++;
    hit2 = 2'b11; cyc(1'b0);
    hit2 = 2'b10; cyc(1'b0);
    hit2 = 2'b00; cyc(1'b0);
    n_checks++;
    if ({state2, score2, draw2} !== {3'd4, 8'h50, 1'b0})
      $display("FAIL match_hits_ignored: got st=%0d score=%h draw=%0b want 4 50 0", state2, score2, draw2);
    else n_pass++;
    keycode = 8'h28; cyc(1'b0);
    keycode = 8'h00;
    n_checks++;
    if ({state2, rr2, mwv2, draw2, score2} !== {3'd1, 1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL match_restart: got st=%0d rr=%0b vld=%0b draw=%0b score=%h want 1 1 0 0 00",
               state2, rr2, mwv2, draw2, score2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_play();
    run_cd();
    repeat (3) begin
      hit2 = 2'b10; cyc(1'b0);
      hit2 = 2'b00;
      run_ro();
      run_cd();
    end
    n_checks++;
    if ({state2, score2, rw2} !== {3'd2, 8'h03, 1'b0})
      $display("FAIL pre_reset: got st=%0d score=%h rw=%0d want 2 03 0", state2, score2, rw2);
    else n_pass++;
    Reset = 1'b1; cyc(1'b1);
    n_checks++;
    if ({state2, rr2, pe2, draw2, mwv2, cd2, score2, rw2} !== 20'd0)
      $display("FAIL mid_reset: got %h want 0", {state2, rr2, pe2, draw2, mwv2, cd2, score2, rw2});
    else n_pass++;
    Reset = 1'b0; cyc(1'b0);
    n_checks++;
    if ({state2, rr2} !== {3'd0, 1'b0})
      $display("FAIL post_reset: got st=%0d rr=%0b want 0 0", state2, rr2);
    else n_pass++;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    n_rr       = 0;
    Reset      = 1'b1;
    frame_tick = 1'b0;
    keycode    = 8'h00;
    hit2       = 2'b00;
    hit4       = 4'b0000;
    test_reset();
    test_start_countdown();
    test_four_players();
    test_win_round();
    test_draw();
    test_match();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
